// File: rtl/if_stage.sv
`default_nettype none
// ------------------------------------------------------------------------------
// if_stage : MIPS instruction-fetch stage with IF/ID register and redirect count
// Revision : 1.0
// ------------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Instruction_if,
  input  logic             Stall,
  input  logic             Branch_id,
  input  logic             Z,
  input  logic [31:0]      BranchAddr,
  input  logic             J,
  input  logic [31:0]      JumpAddr,
  input  logic             JR,
  input  logic [31:0]      JrAddr,
  output logic [31:0]      PC,
  output logic [31:0]      Instruction_id,
  output logic [31:0]      PC_4_id,
  output logic             Valid_id,
  output logic             Redirect,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc4_q, pc4_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;
  logic        w_redirect;

  assign w_pc_plus4 = pc_q + 32'd4;

  // A bubble in ID carries stale control bits, so it must never steer fetch.
  assign w_redirect = valid_q & ~Stall & (J | JR | (Branch_id & Z));

  always_comb begin
    w_target = BranchAddr;
    if (J)       w_target = JumpAddr;
    else if (JR) w_target = JrAddr;
  end

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (Stall) begin
      pc_d = pc_q;
    end else if (w_redirect) begin
      pc_d    = {w_target[31:2], 2'b00};
      instr_d = NOP;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
      if (cnt_q != C_CNT_MAX) cnt_d = cnt_q + C_CNT_ONE;
    end else begin
      pc_d    = w_pc_plus4;
      instr_d = Instruction_if;
      pc4_d   = w_pc_plus4;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PC             = pc_q;
  assign Instruction_id = instr_q;
  assign PC_4_id        = pc4_q;
  assign Valid_id       = valid_q;
  assign Redirect       = w_redirect;
  assign FlushCnt       = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ------------------------------------------------------------------------------
// tb_if_stage : directed self-checking bench for if_stage (FlushCnt width 4)
// Revision    : 1.0
// ------------------------------------------------------------------------------
module tb_if_stage;

  localparam int CW = 4;

  logic          clk;
  logic          reset;
  logic [31:0]   Instruction_if;
  logic          Stall, Branch_id, Z, J, JR;
  logic [31:0]   BranchAddr, JumpAddr, JrAddr;
  logic [31:0]   PC, Instruction_id, PC_4_id;
  logic          Valid_id, Redirect;
  logic [CW-1:0] FlushCnt;

  int checks = 0;
  int errors = 0;

  if_stage #(.RESET_PC(32'h0), .NOP(32'h0), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .Instruction_if(Instruction_if), .Stall(Stall),
    .Branch_id(Branch_id), .Z(Z), .BranchAddr(BranchAddr), .J(J),
    .JumpAddr(JumpAddr), .JR(JR), .JrAddr(JrAddr), .PC(PC),
    .Instruction_id(Instruction_id), .PC_4_id(PC_4_id), .Valid_id(Valid_id),
    .Redirect(Redirect), .FlushCnt(FlushCnt)
  );

  // Instruction memory: fixed addi word at address 0, address-tagged words elsewhere
  assign Instruction_if = (PC == 32'h0) ? 32'h2008_0005 : (PC ^ 32'hA5A5_0000);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_if(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                        input logic [31:0] pc4, input logic v, input logic [CW-1:0] cnt);
    chk({tag, "_pc"},    PC, pc);
    chk({tag, "_instr"}, Instruction_id, ins);
    chk({tag, "_pc4"},   PC_4_id, pc4);
    chk({tag, "_valid"}, {31'd0, Valid_id}, {31'd0, v});
    chk({tag, "_cnt"},   {28'd0, FlushCnt}, {28'd0, cnt});
  endtask

  initial begin
    reset = 1'b1; Stall = 0; Branch_id = 0; Z = 0; J = 0; JR = 0;
    BranchAddr = 0; JumpAddr = 0; JrAddr = 0;
    #11;
    chk_if("rst", 32'h0, 32'h0, 32'h0, 1'b0, 4'd0);
    reset = 1'b0;

    tick();
    chk_if("seq1", 32'h4, 32'h2008_0005, 32'h4, 1'b1, 4'd0);
    chk("seq1_redir", {31'd0, Redirect}, 32'd0);
    tick();
    chk_if("seq2", 32'h8, 32'hA5A5_0004, 32'h8, 1'b1, 4'd0);

    Branch_id = 1; Z = 1; BranchAddr = 32'h40;
    #1 chk("beq_redir", {31'd0, Redirect}, 32'd1);
    tick();
    chk_if("beq_taken", 32'h40, 32'h0, 32'h0, 1'b0, 4'd1);
    chk("bubble_noredir", {31'd0, Redirect}, 32'd0);
    tick();
    chk_if("after_bubble", 32'h44, 32'hA5A5_0040, 32'h44, 1'b1, 4'd1);
    Z = 0;
    #1 chk("beq_nt_redir", {31'd0, Redirect}, 32'd0);
    tick();
    chk_if("beq_nt", 32'h48, 32'hA5A5_0044, 32'h48, 1'b1, 4'd1);

    Stall = 1; Z = 1; BranchAddr = 32'h80;
    #1 chk("stall_redir", {31'd0, Redirect}, 32'd0);
    tick();
    chk_if("stall1", 32'h48, 32'hA5A5_0044, 32'h48, 1'b1, 4'd1);
    tick();
    chk_if("stall2", 32'h48, 32'hA5A5_0044, 32'h48, 1'b1, 4'd1);
    Stall = 0;
    #1 chk("unstall_redir", {31'd0, Redirect}, 32'd1);
    tick();
    chk_if("unstall_br", 32'h80, 32'h0, 32'h0, 1'b0, 4'd2);

    Branch_id = 0; Z = 0;
    tick();
    chk_if("refill", 32'h84, 32'hA5A5_0080, 32'h84, 1'b1, 4'd2);
    J = 1; JR = 1; Branch_id = 1; Z = 1;
    JumpAddr = 32'h103; JrAddr = 32'h200; BranchAddr = 32'h300;
    tick();
    chk_if("prio_j", 32'h100, 32'h0, 32'h0, 1'b0, 4'd3);
    J = 0;
    tick();
    chk("jr_bubble_pc", PC, 32'h104);
    tick();
    chk_if("prio_jr", 32'h200, 32'h0, 32'h0, 1'b0, 4'd4);

    JR = 0; Branch_id = 0; Z = 0;
    tick();
    chk("pre_wrap_pc", PC, 32'h204);
    J = 1; JumpAddr = 32'hFFFF_FFFC;
    tick();
    chk_if("jmp_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 4'd5);
    J = 0;
    tick();
    chk_if("wrap", 32'h0, 32'h5A5A_FFFC, 32'h0, 1'b1, 4'd5);

    JumpAddr = 32'h1000;
    for (int i = 0; i < 10; i++) begin
      J = 1;
      tick();
      J = 0;
      tick();
    end
    chk("sat_reach", {28'd0, FlushCnt}, 32'd15);
    J = 1;
    tick();
    chk("sat_pc", PC, 32'h1000);
    chk("sat_hold", {28'd0, FlushCnt}, 32'd15);

    // Asynchronous reset in the middle of a stall with a jump pending
    J = 0;
    tick();
    Stall = 1; J = 1;
    #2 reset = 1'b1;
    #1 chk_if("rst_async", 32'h0, 32'h0, 32'h0, 1'b0, 4'd0);
    Stall = 0; J = 0;
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("rst_pc4", PC, 32'h4);
    tick();
    chk("rst_pc8", PC, 32'h8);
    chk("rst_instr", Instruction_id, 32'hA5A5_0004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
